// File: rtl/prim_arb_req_fifo_lane.sv
// One requester lane: a register-based FIFO whose head entry is presented to the arbiter.
// Latency: a push is visible on req_o/data_o after 1 edge, and a grant pops at the same edge.
// Backpressure: in_ready_o drops when the lane is full, and a same-cycle pop does not reopen it.
module prim_arb_req_fifo_lane #(
  parameter int DW    = 32,
  parameter int Depth = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          req_o,
  output logic [DW-1:0] data_o,
  input  logic          gnt_i,
  output logic          gnt_empty_o
);
  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

  logic [DW-1:0]   mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  assign in_ready_o  = (cnt_q != CntFull);
  assign req_o       = (cnt_q != '0);
  assign data_o      = mem_q[rd_ptr_q];
  assign push        = in_valid_i & in_ready_o;
  // A grant to an empty lane is reported upward and otherwise ignored.
  assign pop         = gnt_i & req_o;
  assign gnt_empty_o = gnt_i & ~req_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/prim_arb_req_fifo.sv
// N-lane request buffer in front of the arbiter, with a sticky grant-protocol error.
// Latency: push-to-request takes 1 cycle, and grant-to-pop takes 0 cycles because pops happen at the sampling edge.
// Backpressure: each lane's in_ready_o is low while that lane is full; every output comes from registers.
module prim_arb_req_fifo #(
  parameter int N     = 8,
  parameter int DW    = 32,
  parameter int Depth = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  in_valid_i,
  output logic [N-1:0]  in_ready_o,
  input  logic [DW-1:0] in_data_i [N],
  output logic [N-1:0]  req_o,
  output logic [DW-1:0] data_o [N],
  input  logic [N-1:0]  gnt_i,
  output logic          err_o
);
  logic [N-1:0] gnt_empty;
  logic         gnt_multi;
  logic         err_q;

  for (genvar g = 0; g < N; g++) begin : gen_lane
    prim_arb_req_fifo_lane #(
      .DW    (DW),
      .Depth (Depth)
    ) u_lane (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i[g]),
      .in_ready_o  (in_ready_o[g]),
      .in_data_i   (in_data_i[g]),
      .req_o       (req_o[g]),
      .data_o      (data_o[g]),
      .gnt_i       (gnt_i[g]),
      .gnt_empty_o (gnt_empty[g])
    );
  end

  // Clearing the lowest set bit leaves a nonzero value only when more than one grant bit is set.
  assign gnt_multi = |(gnt_i & (gnt_i - N'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (gnt_multi || (|gnt_empty)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_prim_arb_req_fifo.sv
// Directed and short random traffic, checked against a per-lane queue scoreboard and a sticky error model.
module tb_prim_arb_req_fifo;
  localparam int N     = 8;
  localparam int DW    = 32;
  localparam int Depth = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N-1:0]  in_valid_i = '0;
  logic [N-1:0]  in_ready_o;
  logic [DW-1:0] in_data_i [N];
  logic [N-1:0]  req_o;
  logic [DW-1:0] data_o [N];
  logic [N-1:0]  gnt_i = '0;
  logic          err_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb [N][$];
  logic          err_m = 1'b0;

  prim_arb_req_fifo #(
    .N     (N),
    .DW    (DW),
    .Depth (Depth)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .req_o      (req_o),
    .data_o     (data_o),
    .gnt_i      (gnt_i),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_req, exp_rdy;
    for (int i = 0; i < N; i++) begin
      exp_req[i] = (sb[i].size() != 0);
      exp_rdy[i] = (sb[i].size() != Depth);
      if (sb[i].size() != 0) chk($sformatf("head_data[%0d]", i), data_o[i], sb[i][0]);
    end
    chk("req_o", DW'(req_o), DW'(exp_req));
    chk("in_ready_o", DW'(in_ready_o), DW'(exp_rdy));
    chk("err_o", DW'(err_o), DW'(err_m));
  endtask

  // Advances one edge; the scoreboard pops and pushes according to the inputs held across that edge.
  task automatic tick();
    logic [N-1:0] pop_v, push_v;
    logic         err_n;
    err_n = err_m | ((gnt_i & (gnt_i - N'(1))) != '0);
    for (int i = 0; i < N; i++) begin
      pop_v[i]  = gnt_i[i] && (sb[i].size() != 0);
      push_v[i] = in_valid_i[i] && (sb[i].size() != Depth);
      if (gnt_i[i] && sb[i].size() == 0) err_n = 1'b1;
      if (pop_v[i]) chk($sformatf("pop_data[%0d]", i), data_o[i], sb[i][0]);
    end
    @(posedge clk_i);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pop_v[i])  void'(sb[i].pop_front());
      if (push_v[i]) sb[i].push_back(in_data_i[i]);
    end
    err_m = err_n;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    in_valid_i = '1;
    gnt_i      = '0;
    for (int i = 0; i < N; i++) in_data_i[i] = 32'hDEAD_0000 + DW'(i);
    #1;
    for (int i = 0; i < N; i++) sb[i].delete();
    err_m = 1'b0;
    chk("rst_req_o", DW'(req_o), '0);
    chk("rst_err_o", DW'(err_o), '0);
    chk("rst_in_ready_o", DW'(in_ready_o), DW'({N{1'b1}}));
    for (int i = 0; i < N; i++) chk($sformatf("rst_data_o[%0d]", i), data_o[i], '0);
    @(posedge clk_i);
    #1;
    chk("rst_hold_req_o", DW'(req_o), '0);
    @(negedge clk_i);
    in_valid_i = '0;
    rst_ni     = 1'b1;
    @(posedge clk_i);
    #1;
    check_outputs();
  endtask

  initial begin
    int l;
    for (int i = 0; i < N; i++) in_data_i[i] = '0;
    do_reset();

    // Single push on lane 3 becomes visible one cycle later.
    in_valid_i = 8'h08; in_data_i[3] = 32'hA5;
    tick();
    chk("push_req_o", DW'(req_o), 32'h08);
    chk("push_data3", data_o[3], 32'hA5);
    in_valid_i = '0; gnt_i = 8'h08;
    tick();
    gnt_i = '0;

    // Fill lane 0; the third push is refused.
    in_valid_i = 8'h01; in_data_i[0] = 32'h11; tick();
    in_data_i[0] = 32'h22; tick();
    chk("full_ready0", DW'(in_ready_o[0]), '0);
    in_data_i[0] = 32'h33; tick();
    in_valid_i = '0; gnt_i = 8'h01;
    chk("drain_first", data_o[0], 32'h11);
    tick();
    chk("drain_second", data_o[0], 32'h22);
    tick();
    gnt_i = '0;
    chk("drained_req0", DW'(req_o[0]), '0);

    // Lane 5: simultaneous push and pop over several pointer wraps.
    in_valid_i = 8'h20; in_data_i[5] = 32'h50; tick();
    gnt_i = 8'h20;
    for (int k = 0; k < 10; k++) begin
      in_data_i[5] = 32'h60 + DW'(k);
      tick();
      chk("pp_data5", data_o[5], 32'h60 + DW'(k));
      chk("pp_req5", DW'(req_o[5]), 32'h1);
    end
    in_valid_i = '0;
    tick();
    gnt_i = '0;

    // Random traffic with legal one-hot grants to non-empty lanes.
    for (int c = 0; c < 40; c++) begin
      in_valid_i = N'($urandom);
      for (int i = 0; i < N; i++) in_data_i[i] = $urandom;
      l = $urandom_range(0, N - 1);
      gnt_i = (sb[l].size() != 0) ? (N'(1) << l) : '0;
      tick();
    end
    in_valid_i = '0; gnt_i = '0;
    do_reset();

    // A grant to an empty lane sets the sticky error and cannot underflow the lane.
    gnt_i = 8'h04; tick();
    chk("err_empty_gnt", DW'(err_o), 32'h1);
    gnt_i = '0; tick(); tick();
    chk("err_sticky", DW'(err_o), 32'h1);
    in_valid_i = 8'h04; in_data_i[2] = 32'h77; tick();
    in_valid_i = '0;
    chk("no_underflow_req2", DW'(req_o[2]), 32'h1);
    chk("no_underflow_data2", data_o[2], 32'h77);
    gnt_i = 8'h04; tick();
    gnt_i = '0;
    do_reset();

    // A multi-hot grant still pops both lanes and raises the error.
    in_valid_i = 8'h06; in_data_i[1] = 32'h81; in_data_i[2] = 32'h82; tick();
    in_valid_i = '0; gnt_i = 8'h06; tick();
    gnt_i = '0;
    chk("err_multi", DW'(err_o), 32'h1);
    chk("multi_popped", DW'(req_o & 8'h06), '0);
    tick();
    chk("err_multi_sticky", DW'(err_o), 32'h1);
    do_reset();
    chk("err_cleared", DW'(err_o), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
